alu_hs: RTL

- Next-generation parametrised ALU that replaces the fixed add/sub pipeline.
- Uses a valid/ready handshake on both sides, supports an extended operation set and produces status flags.
- Supports an optional iterative multiply that takes WIDTH cycles.
- Sits between an operand-issue stage and a result consumer that may apply backpressure; processes one operation at a time.

---
 rtl/alu_hs_pkg.sv | 31 +++
 rtl/alu_mul_seq.sv | 64 ++++++
 rtl/alu_hs.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_hs_pkg.sv
// alu_hs_pkg: shared types and constants for the handshake ALU.
//   alu_op_t    - 4-bit opcode encoding presented on op_in
//   alu_state_t - control FSM state encoding
//   FLAG_*      - bit positions inside the 4-bit {n,z,c,v} flags vector
package alu_hs_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial product
// per clock, WIDTH clocks per operation.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - load a/b and begin (ignored while busy by the caller)
//   a, b         - operands
//   busy         - an operation is in progress
//   done         - final step is being taken this cycle; product is final
//   product      - running sum including the current step's partial product
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_next;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_next   = r_acc + w_addend;

  // product is exposed combinationally so the caller can capture the final
  // value on the same edge that retires the last step.
  assign product = w_next;
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_hs.sv
// alu_hs: single-issue ALU with valid/ready handshakes on both sides.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - operation handshake (ready only when idle)
//   op_in, a_in, b_in    - opcode (alu_op_t) and operands
//   out, flags, err      - registered result, {n,z,c,v}, illegal-op flag
//   out_valid/out_ready  - result handshake; result held until taken
// Simple ops take one EXEC cycle; MUL (when MUL_EN) runs the iterative
// multiplier for WIDTH cycles. Illegal opcodes return out=0, flags=0, err=1.
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;
  logic             r_err;
  logic             r_out_valid;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [3:0]         w_mul_flags;

  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_err;
  logic [3:0]         w_flags;
  logic [WIDTH:0]     w_sum;
  logic [SHW-1:0]     w_shamt;
  logic [2*WIDTH-1:0] w_shl;
  logic [2*WIDTH-1:0] w_shr;

  // Gated by rst_n so the issue stage never sees ready during reset.
  assign in_ready = (r_state == ST_IDLE) && rst_n;
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (MUL_EN != 0) && (op_in == OP_MUL);

  assign out       = r_out;
  assign flags     = r_flags;
  assign err       = r_err;
  assign out_valid = r_out_valid;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept && w_is_mul),
        .a       (a_in),
        .b       (b_in),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
      );
    end else begin : g_no_mul
      assign w_mul_busy    = 1'b0;
      assign w_mul_done    = 1'b0;
      assign w_mul_product = '0;
    end
  endgenerate

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_N] = w_mul_product[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_mul_product[WIDTH-1:0] == '0);
    w_mul_flags[FLAG_C] = |w_mul_product[2*WIDTH-1:WIDTH];
  end

  // Shifts are done in a double-width window so the last bit shifted out
  // lands at a fixed position (WIDTH for SHL, WIDTH-1 for SHR); a zero
  // shift leaves a zero there, which gives c=0 without a special case.
  assign w_shamt = r_b[SHW-1:0];
  assign w_shl   = {{WIDTH{1'b0}}, r_a} << w_shamt;
  assign w_shr   = {r_a, {WIDTH{1'b0}}} >> w_shamt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    w_sum = '0;
    case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[2*WIDTH-1:WIDTH];
        w_c   = w_shr[WIDTH-1];
      end
      // MUL never reaches EXEC when implemented, so here it is illegal.
      default: w_err = 1'b1;
    endcase

    w_flags = '0;
    if (!w_err) begin
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_C] = w_c;
      w_flags[FLAG_V] = w_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= op_in;
            r_a  <= a_in;
            r_b  <= b_in;
            if (op_in == OP_NOP) r_state <= ST_IDLE;
            else if (w_is_mul)   r_state <= ST_MUL;
            else                 r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_out       <= w_res;
          r_flags     <= w_flags;
          r_err       <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_out       <= w_mul_product[WIDTH-1:0];
            r_flags     <= w_mul_flags;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (!w_mul_busy) begin
            // Multiplier idle without finishing: never wait forever.
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
